elastic_pipe_reg: RTL
=====================

// Module: elastic_pipe_reg
// PURPOSE
// - Parametrised inter-stage pipeline register chain: DEPTH elastic stages with valid/ready handshake,
//   stall back-pressure, flush squash with NOP injection, optional keep-on-flush of the incoming beat.
// - Replaces hand-written F->DE / DE->MW registers; sits between any two datapath stages.
// PARAMETERS
// - DATA_W   64            payload width (e.g. {pc,inst})
// - DEPTH    1             number of register stages, legal 1..4
// - INST_LSB 0             bit position of instruction field inside payload
// - INST_W   32            instruction field width; INST_LSB+INST_W <= DATA_W
// - NOP_VAL  32'h00000013  value forced into instruction field of invalid/squashed stages
// PORTS
// - clk         in   1       clock, all state on posedge
// - rst         in   1       asynchronous active-low reset
// - flush       in   1       squash all stages this cycle
// - flush_keep  in   1       with flush: retain incoming beat in stage 0 instead of dropping it
// - in_valid    in   1       upstream beat valid
// - in_ready    out  1       chain accepts beat this cycle
// - in_data     in   DATA_W  upstream payload
// - out_valid   out  1       last stage holds valid beat
// - out_ready   in   1       downstream accepts beat
// - out_data    out  DATA_W  last-stage payload (inst field masked, see below)
// BEHAVIOUR
// - One clock (clk); reset asynchronous, active-low (rst). Reset: all valid=0, all stage data=0;
//   out_valid=0, in_ready=1, out_data = 0 with inst field = NOP_VAL.
// - Stage k (0=input side, DEPTH-1=output) holds v[k], d[k]. rdy[DEPTH]=out_ready;
//   rdy[k] = !v[k] | rdy[k+1]; in_ready = rdy[0] (combinational, no skid).
// - Normal cycle: stage k loads stage k-1 (stage 0 loads in_data/in_valid) when rdy[k]; else holds.
// - Latency: DEPTH cycles in->out with no stall; throughput 1 beat/cycle with out_ready=1.
// - Stall: out_ready=0 with all v=1 -> in_ready=0, all stages hold data bit-exact.
// - Bubbles compress: invalid stage always loads from its predecessor even if downstream stalled.
// - Flush (priority over stall): in_ready=1; next state v[1..DEPTH-1]=0; pc/other fields of
//   squashed stages keep their values, inst field <= NOP_VAL.
//   Stage 0: flush_keep & in_valid -> loads in_data, v[0]=1; otherwise v[0]=0, inst=NOP_VAL,
//   other fields <= in_data (beat consumed and discarded).
// - Flush does not qualify the output handshake: out_valid&out_ready in the flush cycle is a
//   completed transfer; downstream gates commit itself.
// - out_data inst field forced to NOP_VAL whenever out_valid=0 (combinational mask).
// - flush_keep ignored when flush=0. X on in_data with in_valid=0 must not propagate to out_data
//   inst field.
// - Reset asserted mid-stall/mid-flush: state cleared immediately, no beat emitted.
// CONFIGURATION
// - PIPE_PERF_CNT_EN defined: adds ports perf_clr in 1, perf_stall_cnt out 32, perf_squash_cnt out 32.
//   stall_cnt += 1 each cycle out_valid&!out_ready; squash_cnt += number of valid stages
//   killed by flush (plus 1 for incoming beat dropped with flush_keep=0 & in_valid).
//   Both saturate at 32'hFFFF_FFFF, reset to 0, perf_clr synchronous clear (clr wins over increment).
// - Not defined: ports and counters absent; datapath behaviour identical.
// TESTING
// - DEPTH=2, out_ready=1, stream inst 0x00A00093,0x00B00113 -> appear on out_data 2 cycles later, back-to-back.
// - DEPTH=2, full chain, out_ready=0 for 5 cycles -> in_ready=0, out_data stable 5 cycles, no beat lost on release.
// - DEPTH=1, flush=1, flush_keep=0, in_valid=1 pc=0x100 -> next cycle out_valid=0, out_data inst=0x00000013, pc=0x100.
// - DEPTH=1, flush=1, flush_keep=1, in inst=0x00000063 -> next cycle out_valid=1, out_data inst=0x00000063.
// - DEPTH=3, bubble in stage 1, stall out -> stage 0 advances into stage 1; flush during stall -> all v=0 next cycle.
// - PIPE_PERF_CNT_EN: 3 stall cycles then flush with 2 valid stages -> stall_cnt=3, squash_cnt=2; perf_clr -> 0,0.

Source files
------------

// File: rtl/elastic_pipe_reg.sv
// Elastic inter-stage pipeline register chain: DEPTH valid/ready stages with
// stall back-pressure, flush squash with NOP injection and optional retention of
// the incoming beat on flush (flush_keep).
// Optional build macro PIPE_PERF_CNT_EN adds saturating stall/squash counters.
module elastic_pipe_reg #(
  parameter int unsigned       DATA_W   = 64,
  parameter int unsigned       DEPTH    = 1,
  parameter int unsigned       INST_LSB = 0,
  parameter int unsigned       INST_W   = 32,
  parameter logic [INST_W-1:0] NOP_VAL  = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              flush_keep,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_PERF_CNT_EN
  ,
  input  logic              perf_clr,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_squash_cnt
`endif
);

  localparam int unsigned CNT_W = 32;
  localparam int unsigned INC_W = 3;

  // Elaboration-time parameter legality
  if (DEPTH < 1 || DEPTH > 4 || INST_LSB + INST_W > DATA_W) begin : g_bad_params
    $error("elastic_pipe_reg: illegal DEPTH or instruction field placement");
  end

  logic [DEPTH-1:0]  v_q;
  logic [DEPTH-1:0]  v_d;
  logic [DATA_W-1:0] d_q [DEPTH];
  logic [DATA_W-1:0] d_d [DEPTH];
  logic [DEPTH-1:0]  rdy_c;

  // Replace the instruction field with the NOP encoding, other fields untouched
  function automatic logic [DATA_W-1:0] nop_inst(input logic [DATA_W-1:0] x);
    logic [DATA_W-1:0] r;
    r = x;
    r[INST_LSB +: INST_W] = NOP_VAL;
    return r;
  endfunction

  // Per-stage ready: a stage can load if it is empty or everything after it moves
  always_comb begin
    logic acc;
    acc   = out_ready;
    rdy_c = '0;
    for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
      acc      = ~v_q[k] | acc;
      rdy_c[k] = acc;
    end
  end

  assign in_ready  = flush | rdy_c[0];
  assign out_valid = v_q[DEPTH-1];
  assign out_data  = v_q[DEPTH-1] ? d_q[DEPTH-1] : nop_inst(d_q[DEPTH-1]);

  // Next-state: flush squashes everything; otherwise shift where ready.
  // Invalid beats are stored with a NOP instruction so X never reaches the output field.
  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (flush) begin
      for (int k = 1; k < int'(DEPTH); k++) begin
        v_d[k] = 1'b0;
        d_d[k] = nop_inst(d_q[k]);
      end
      if (flush_keep && in_valid) begin
        v_d[0] = 1'b1;
        d_d[0] = in_data;
      end else begin
        v_d[0] = 1'b0;
        d_d[0] = nop_inst(in_data);
      end
    end else begin
      if (rdy_c[0]) begin
        v_d[0] = in_valid;
        d_d[0] = in_valid ? in_data : nop_inst(in_data);
      end
      for (int k = 1; k < int'(DEPTH); k++) begin
        if (rdy_c[k]) begin
          v_d[k] = v_q[k-1];
          d_d[k] = d_q[k-1];
        end
      end
    end
  end

  // Stage registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_q <= '0;
      for (int k = 0; k < int'(DEPTH); k++) begin
        d_q[k] <= '0;
      end
    end else begin
      v_q <= v_d;
      for (int k = 0; k < int'(DEPTH); k++) begin
        d_q[k] <= d_d[k];
      end
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic             stall_c;
  logic [INC_W-1:0] squash_inc_c;
  logic [CNT_W:0]   squash_sum_c;

  // Count beats killed by a flush; a last-stage beat taken by downstream is not killed
  always_comb begin
    stall_c      = v_q[DEPTH-1] & ~out_ready;
    squash_inc_c = '0;
    if (flush) begin
      for (int k = 0; k < int'(DEPTH); k++) begin
        if (v_q[k] && !((k == int'(DEPTH) - 1) && out_ready)) begin
          squash_inc_c = squash_inc_c + INC_W'(1);
        end
      end
      if (in_valid && !flush_keep) begin
        squash_inc_c = squash_inc_c + INC_W'(1);
      end
    end
    squash_sum_c = {1'b0, perf_squash_cnt} + (CNT_W + 1)'(squash_inc_c);
  end

  // Saturating performance counters, synchronous clear has priority
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_cnt  <= '0;
      perf_squash_cnt <= '0;
    end else if (perf_clr) begin
      perf_stall_cnt  <= '0;
      perf_squash_cnt <= '0;
    end else begin
      if (stall_c && perf_stall_cnt != '1) begin
        perf_stall_cnt <= perf_stall_cnt + CNT_W'(1);
      end
      perf_squash_cnt <= squash_sum_c[CNT_W] ? '1 : squash_sum_c[CNT_W-1:0];
    end
  end
`endif

endmodule
